lpc_clkgen_nco: RTL

Parametrised multi-channel clock-enable generator for the LPC design, running entirely in the `refclk` domain. Each channel is an NCO (phase accumulator) whose carry-out becomes a single-cycle clock-enable. Channels have programmable rate and phase, so any number of slow sample/frame rates (e.g. 0.8 MHz from 50 MHz) are produced without extra PLL outputs. A lock/settle state machine gates all outputs until configuration is stable, mirroring PLL `locked` semantics for downstream logic.

---
 rtl/lpc_clkgen_nco.sv | 135 +++++++++++++
 1 files changed

// File: rtl/lpc_clkgen_nco.sv
// lpc_clkgen_nco: multi-channel NCO clock-enable generator whose outputs are held off until a lock/settle FSM reports stable configuration.
// Optional feature macro LPC_CLKGEN_SQUARE_EN adds a per-channel ~50% square wave on sq_out.
module lpc_clkgen_nco #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] sq_out,
    output logic              locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ACC_W-1:0]  acc     [NUM_CH];
    logic [ACC_W-1:0]  inc     [NUM_CH];
    logic [ACC_W-1:0]  acc_nxt [NUM_CH];
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] wr_sel;
    logic              wr_valid;

    // Out-of-range channel indices (possible when NUM_CH is not a power of two) are dropped.
    assign wr_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    assign locked   = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                cnt_nxt = cnt;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A fresh write restarts settling even on the cycle the counter would have completed.
        if (run && wr_valid) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
        end
        if (!run) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_nxt[i] = acc[i];
            carry[i]   = 1'b0;
            wr_sel[i]  = wr_valid && (cfg_ch == CH_W'(i));
            if (state != IDLE && !wr_sel[i]) begin
                {carry[i], acc_nxt[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ce_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ce_out <= (state_nxt == LOCKED) ? carry : '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sel[i]) begin
                    acc[i] <= cfg_phase;
                    inc[i] <= cfg_inc;
                end else begin
                    acc[i] <= acc_nxt[i];
                end
            end
        end
    end

`ifdef LPC_CLKGEN_SQUARE_EN
    logic [NUM_CH-1:0] acc_msb;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_msb[i] = acc[i][ACC_W-1];
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sq_out <= '0;
        end else begin
            sq_out <= (state_nxt == LOCKED) ? acc_msb : '0;
        end
    end
`else
    assign sq_out = '0;
`endif

endmodule
